serial_frame_ctrl: RTL

SERIAL_FRAME_CTRL -- requirements
Module: serial_frame_ctrl

---
 rtl/serial_frame_ctrl_pkg.sv | 19 +
 rtl/serial_frame_ctrl_piso.sv | 30 +++
 rtl/serial_frame_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/serial_frame_ctrl_pkg.sv
// Shared types and constants for the serial frame controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package serial_frame_ctrl_pkg;

    // Frame FSM states. The ST_ prefix keeps the literals distinct from the
    // controller's GAP parameter when both are visible in the same scope.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_GAP
    } frameStateT;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_frame_ctrl_piso.sv
// Parallel-in serial-out shift register, LSB presented first.
// Latency: dIn[0] appears on sOut the cycle after load; one bit per shift.
// Backpressure: none; load takes priority over shift.
// Ports: clk, rst (async active-low), load, shift, dIn[WIDTH], sOut (= register LSB).
module shift_reg_piso #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] dIn,
    output logic             sOut
);

    logic [WIDTH-1:0] shReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shReg <= '0;
        end else if (load) begin
            shReg <= dIn;
        end else if (shift) begin
            shReg <= {1'b0, shReg[WIDTH-1:1]};
        end
    end

    assign sOut = shReg[0];

endmodule

// File: rtl/serial_frame_ctrl.sv
// Serialises WIDTH-bit words into start/data(LSB first)/stop frames plus GAP idle cycles.
// Latency: start bit one cycle after accept; frame period WIDTH+3+GAP cycles.
// Backpressure: pReady high only in IDLE; producer holds pValid until accepted.
// Ports: clk, rst (async active-low), pData/pValid/pReady (word handshake),
//        sOut (serial line, idle 1), busy (not IDLE), done (high during stop bit).
module serial_frame_ctrl
    import serial_frame_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pData,
    input  logic             pValid,
    output logic             pReady,
    output logic             sOut,
    output logic             busy,
    output logic             done
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [3:0]        GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);

    frameStateT       state;
    frameStateT       stateNext;
    logic [CNT_W-1:0] bitCnt;
    logic [3:0]       gapCnt;
    logic             accept;
    logic             shiftEn;
    logic             shiftLsb;

    assign accept  = (state == ST_IDLE) && pValid;
    assign shiftEn = (state == ST_DATA);

    shift_reg_piso #(
        .WIDTH (WIDTH)
    ) uPiso (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shiftEn),
        .dIn   (pData),
        .sOut  (shiftLsb)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:  if (pValid) stateNext = ST_START;
            ST_START: stateNext = ST_DATA;
            ST_DATA:  if (bitCnt == LAST_BIT) stateNext = ST_STOP;
            ST_STOP:  stateNext = (GAP == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (gapCnt == GAP_LAST) stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    // Both counters sit at zero outside their own state, so each starts
    // cleared on entry and leaves its state before it could wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitCnt <= '0;
        end else if (state != ST_DATA) begin
            bitCnt <= '0;
        end else begin
            bitCnt <= bitCnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gapCnt <= '0;
        end else if (state != ST_GAP) begin
            gapCnt <= '0;
        end else begin
            gapCnt <= gapCnt + 4'd1;
        end
    end

    // Outputs depend only on registered state and the shift-register LSB.
    always_comb begin
        sOut = STOP_BIT;
        case (state)
            ST_START: sOut = START_BIT;
            ST_DATA:  sOut = shiftLsb;
            default:  sOut = STOP_BIT;
        endcase
    end

    assign pReady = (state == ST_IDLE);
    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_STOP);

endmodule
